// File: rtl/s_array_pkg.sv
// Shared types and constants for the S-array scheduler: run modes, FSM states
// and the per-entry cycle cost of the key-scheduling swap pass.
package s_array_pkg;

  typedef enum logic [1:0] {
    MODE_IDENTITY = 2'd0,
    MODE_FILL     = 2'd1,
    MODE_KSA      = 2'd2,
    MODE_FULL     = 2'd3
  } mode_t;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_INIT       = 4'd1,
    S_KSA_RD_I   = 4'd2,
    S_KSA_WAIT_I = 4'd3,
    S_KSA_RD_J   = 4'd4,
    S_KSA_WAIT_J = 4'd5,
    S_KSA_WR_I   = 4'd6,
    S_KSA_WR_J   = 4'd7,
    S_DONE       = 4'd8
  } state_t;

  localparam int KSA_CYCLES_PER_ENTRY = 6;

  function automatic logic is_busy_state(input state_t s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/s_array_sched_chk.sv
// Elaboration-time parameter checks for s_array_sched; holds no logic.
module s_array_sched_chk #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int KEY_BYTES = 3
) ();

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_pow2
    $error("s_array_sched: DEPTH must be a power of two >= 2");
  end

  if (DEPTH > (2 ** DATA_W)) begin : g_depth_fits
    $error("s_array_sched: DEPTH must not exceed 2**DATA_W");
  end

  if (KEY_BYTES < 1) begin : g_key_len
    $error("s_array_sched: KEY_BYTES must be at least 1");
  end

endmodule

// File: rtl/s_array_sched_key_byte_sel.sv
// Picks key byte k out of the registered key; byte 0 is the most significant.
module key_byte_sel #(
  parameter int KEY_BYTES = 3,
  parameter int KW        = 2
) (
  input  logic [8*KEY_BYTES-1:0] i_key,
  input  logic [KW-1:0]          i_k,
  output logic [7:0]             o_byte
);

  // Byte mux over the key bytes
  always_comb begin
    o_byte = 8'h00;
    for (int n = 0; n < KEY_BYTES; n++) begin
      o_byte = (i_k == KW'(n)) ? i_key[8*(KEY_BYTES-1-n) +: 8] : o_byte;
    end
  end

endmodule

// File: rtl/s_array_sched.sv
// S-array scheduler: drives a single-port RAM (1-cycle read latency) for identity fill,
// constant fill, the RC4 key-scheduling swap pass, or identity fill followed by the swap pass.
module s_array_sched
  import s_array_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int KEY_BYTES = 3,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [DATA_W-1:0]      fill_value,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [ADDR_W-1:0]      array_address,
  output logic [DATA_W-1:0]      data,
  output logic                   write_enable,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   busy,
  output logic                   finish
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  state_t                 r_state, w_state_nxt;
  mode_t                  r_mode, w_mode_nxt;
  logic [DATA_W-1:0]      r_fill, w_fill_nxt;
  logic [8*KEY_BYTES-1:0] r_key, w_key_nxt;
  logic [ADDR_W-1:0]      r_i, w_i_nxt, r_j, w_j_nxt;
  logic [KW-1:0]          r_k, w_k_nxt;
  logic [DATA_W-1:0]      r_si, w_si_nxt;
  logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
  logic [DATA_W-1:0]      r_data, w_data_nxt;
  logic                   r_we, w_we_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_finish, w_finish_nxt;
  logic [ADDR_W-1:0]      w_i_inc, w_j_sum;
  logic                   w_i_last, w_k_wrap;
  logic [7:0]             w_key_byte;

  s_array_sched_chk #(.DATA_W(DATA_W), .DEPTH(DEPTH), .KEY_BYTES(KEY_BYTES)) u_chk ();

  key_byte_sel #(.KEY_BYTES(KEY_BYTES), .KW(KW)) u_key_sel (
    .i_key  (r_key),
    .i_k    (r_k),
    .o_byte (w_key_byte)
  );

  // Next-state, counter and RAM-interface decode; outputs are registered from these values
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_fill_nxt  = r_fill;
    w_key_nxt   = r_key;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_si_nxt    = r_si;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_we_nxt    = 1'b0;
    w_i_inc     = r_i + ADDR_W'(1);
    w_i_last    = (r_i == ADDR_W'(DEPTH - 1));
    w_k_wrap    = (r_k == KW'(KEY_BYTES - 1));
    // key byte is zero-extended or truncated to the index width by the cast
    w_j_sum     = r_j + ADDR_W'(rd_data) + ADDR_W'(w_key_byte);
    if (is_busy_state(r_state) && abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            w_mode_nxt = mode_t'(mode);
            w_fill_nxt = fill_value;
            w_key_nxt  = secret_key;
            w_i_nxt    = {ADDR_W{1'b0}};
            w_j_nxt    = {ADDR_W{1'b0}};
            w_k_nxt    = {KW{1'b0}};
            w_addr_nxt = {ADDR_W{1'b0}};
            if (mode_t'(mode) == MODE_KSA) begin
              w_state_nxt = S_KSA_RD_I;
            end else begin
              w_state_nxt = S_INIT;
              w_we_nxt    = 1'b1;
              w_data_nxt  = (mode_t'(mode) == MODE_FILL) ? fill_value : {DATA_W{1'b0}};
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_INIT: begin
          if (w_i_last) begin
            if (r_mode == MODE_FULL) begin
              w_state_nxt = S_KSA_RD_I;
              w_i_nxt     = {ADDR_W{1'b0}};
              w_addr_nxt  = {ADDR_W{1'b0}};
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_i_nxt    = w_i_inc;
            w_addr_nxt = w_i_inc;
            w_data_nxt = (r_mode == MODE_FILL) ? r_fill : DATA_W'(w_i_inc);
            w_we_nxt   = 1'b1;
          end
        end
        S_KSA_RD_I: w_state_nxt = S_KSA_WAIT_I;
        S_KSA_WAIT_I: begin
          w_si_nxt    = rd_data;
          w_j_nxt     = w_j_sum;
          w_addr_nxt  = w_j_sum;
          w_state_nxt = S_KSA_RD_J;
        end
        S_KSA_RD_J: w_state_nxt = S_KSA_WAIT_J;
        S_KSA_WAIT_J: begin
          // S[j] goes straight into the write-data register for the S[i] write
          w_addr_nxt  = r_i;
          w_data_nxt  = rd_data;
          w_we_nxt    = 1'b1;
          w_state_nxt = S_KSA_WR_I;
        end
        S_KSA_WR_I: begin
          w_addr_nxt  = r_j;
          w_data_nxt  = r_si;
          w_we_nxt    = 1'b1;
          w_state_nxt = S_KSA_WR_J;
        end
        S_KSA_WR_J: begin
          w_k_nxt = w_k_wrap ? {KW{1'b0}} : r_k + KW'(1);
          if (w_i_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_i_nxt     = w_i_inc;
            w_addr_nxt  = w_i_inc;
            w_state_nxt = S_KSA_RD_I;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_busy_nxt   = is_busy_state(w_state_nxt);
    w_finish_nxt = (w_state_nxt == S_DONE);
  end

  // State, counters, captured operands and registered RAM interface
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_mode   <= MODE_IDENTITY;
      r_fill   <= {DATA_W{1'b0}};
      r_key    <= {(8*KEY_BYTES){1'b0}};
      r_i      <= {ADDR_W{1'b0}};
      r_j      <= {ADDR_W{1'b0}};
      r_k      <= {KW{1'b0}};
      r_si     <= {DATA_W{1'b0}};
      r_addr   <= {ADDR_W{1'b0}};
      r_data   <= {DATA_W{1'b0}};
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mode   <= w_mode_nxt;
      r_fill   <= w_fill_nxt;
      r_key    <= w_key_nxt;
      r_i      <= w_i_nxt;
      r_j      <= w_j_nxt;
      r_k      <= w_k_nxt;
      r_si     <= w_si_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_we     <= w_we_nxt;
      r_busy   <= w_busy_nxt;
      r_finish <= w_finish_nxt;
    end
  end

  assign array_address = r_addr;
  assign data          = r_data;
  assign write_enable  = r_we;
  assign busy          = r_busy;
  assign finish        = r_finish;

endmodule

// File: tb/tb_s_array_sched.sv
// Bench for s_array_sched: two instances (256x8 / 3-byte key and 16x8 / 1-byte key), each with
// a behavioural 1-cycle-latency RAM, checked against an array-based RC4 key-schedule model.
module tb_s_array_sched;
  import s_array_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start_a, abort_a, start_b, abort_b;
  logic [1:0]  mode_s;
  logic [7:0]  fill_s, key_b;
  logic [23:0] key_a;
  logic [7:0]  addr_a, data_a, rd_a;
  logic        we_a, busy_a, fin_a;
  logic [3:0]  addr_b;
  logic [7:0]  data_b, rd_b;
  logic        we_b, busy_b, fin_b;

  s_array_sched #(.DATA_W(8), .DEPTH(256), .KEY_BYTES(3)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a), .mode(mode_s),
    .fill_value(fill_s), .secret_key(key_a), .array_address(addr_a), .data(data_a),
    .write_enable(we_a), .rd_data(rd_a), .busy(busy_a), .finish(fin_a));

  s_array_sched #(.DATA_W(8), .DEPTH(16), .KEY_BYTES(1)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b), .mode(mode_s),
    .fill_value(fill_s), .secret_key(key_b), .array_address(addr_b), .data(data_b),
    .write_enable(we_b), .rd_data(rd_b), .busy(busy_b), .finish(fin_b));

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];
  int wr_a = 0;

  always @(posedge clk) begin
    if (we_a) begin
      mem_a[addr_a] <= data_a;
      wr_a <= wr_a + 1;
    end
    rd_a <= mem_a[addr_a];
  end

  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= data_b;
    rd_b <= mem_b[addr_b];
  end

  bit         cur_sel = 1'b0;
  logic       fin_c, busy_c, we_c;
  logic [7:0] addr_c, data_c;
  assign fin_c  = cur_sel ? fin_b  : fin_a;
  assign busy_c = cur_sel ? busy_b : busy_a;
  assign we_c   = cur_sel ? we_b   : we_a;
  assign addr_c = cur_sel ? {4'h0, addr_b} : addr_a;
  assign data_c = cur_sel ? data_b : data_a;

  int n_cmp = 0;
  int n_bad = 0;
  int mdl_a [256];
  int mdl_b [16];
  int mdl   [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: identity / fill / RC4 key schedule on a plain integer array
  task automatic model(input int md, input int fill, input logic [23:0] key, input int depth, input int kb);
    int j, t, kbyte;
    if (md == 0 || md == 3) for (int n = 0; n < depth; n++) mdl[n] = n;
    if (md == 1) for (int n = 0; n < depth; n++) mdl[n] = fill;
    if (md >= 2) begin
      j = 0;
      for (int i = 0; i < depth; i++) begin
        kbyte = int'((key >> (8 * (kb - 1 - (i % kb)))) & 24'hFF);
        j = (j + mdl[i] + kbyte) % depth;
        t = mdl[i]; mdl[i] = mdl[j]; mdl[j] = t;
      end
    end
  endtask

  task automatic model_and_cmp(input bit sel, input int md, input int fill, input logic [23:0] key);
    int depth, bad, first;
    logic [7:0] v;
    depth = sel ? 16 : 256;
    for (int n = 0; n < depth; n++) mdl[n] = sel ? mdl_b[n] : mdl_a[n];
    model(md, fill, key, depth, sel ? 1 : 3);
    bad = 0; first = -1;
    for (int n = 0; n < depth; n++) begin
      if (sel) mdl_b[n] = mdl[n]; else mdl_a[n] = mdl[n];
      v = sel ? mem_b[n] : mem_a[n];
      if (v !== 8'(mdl[n])) begin
        bad++;
        if (first < 0) first = n;
      end
    end
    if (bad != 0) $display("  first bad RAM entry %0d (inst %0d)", first, sel);
    chk("ram_contents_bad_entries", bad, 0);
  endtask

  task automatic wait_done(input int start_cyc, output int cyc);
    cyc = start_cyc;
    while (!fin_c && cyc < 4000) begin
      tick;
      cyc++;
    end
  endtask

  task automatic run(input bit sel, input int md, input int fill, input logic [23:0] key,
                     input int exp_cyc, input bit chk_ad, input int exp_ad, input int exp_dat);
    int cyc;
    cur_sel = sel;
    mode_s = 2'(md); fill_s = 8'(fill); key_a = key; key_b = key[7:0];
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick;
    start_a = 1'b0; start_b = 1'b0;
    chk("accept_finish_cleared", fin_c, 0);
    chk("accept_busy", busy_c, 1);
    wait_done(0, cyc);
    chk("run_cycles", cyc, exp_cyc);
    chk("done_busy", busy_c, 0);
    chk("done_we", we_c, 0);
    if (chk_ad) begin
      tick;
      chk("done_finish_held", fin_c, 1);
      chk("done_addr", addr_c, exp_ad);
      chk("done_data", data_c, exp_dat);
    end
    model_and_cmp(sel, md, fill, key);
  endtask

  function automatic int cycles_for(input int md, input int depth);
    if (md == 2) return KSA_CYCLES_PER_ENTRY * depth;
    if (md == 3) return (KSA_CYCLES_PER_ENTRY + 1) * depth;
    return depth;
  endfunction

  typedef struct {
    bit          sel;
    int          md;
    int          fill;
    logic [23:0] key;
    int          cyc;
    bit          chk_ad;
    int          ad;
    int          dat;
  } vec_t;

  vec_t        vt [12];
  logic [7:0]  rf1, rf2;
  logic [23:0] rk1, rk2, rk3;
  int          cyc, w0, sel_r, md_r, d_r, fill_r;
  logic [23:0] key_r;

  initial begin
    rf1 = 8'($urandom); rf2 = 8'($urandom);
    rk1 = 24'($urandom); rk2 = 24'($urandom); rk3 = 24'($urandom);
    vt[0]  = '{1'b0, 0, 0,   24'h0,      256,  1'b1, 255, 255};
    vt[1]  = '{1'b0, 1, 'hA5, 24'h0,     256,  1'b1, 255, 'hA5};
    vt[2]  = '{1'b0, 1, int'(rf1), 24'h0, 256, 1'b1, 255, int'(rf1)};
    vt[3]  = '{1'b0, 3, 0,   24'h000249, 1792, 1'b0, 0, 0};
    vt[4]  = '{1'b0, 2, 0,   rk1,        1536, 1'b0, 0, 0};
    vt[5]  = '{1'b0, 0, 0,   24'h0,      256,  1'b1, 255, 255};
    vt[6]  = '{1'b0, 2, 0,   24'h000249, 1536, 1'b0, 0, 0};
    vt[7]  = '{1'b1, 3, 0,   24'h00005A, 112,  1'b0, 0, 0};
    vt[8]  = '{1'b1, 2, 0,   rk2,        96,   1'b0, 0, 0};
    vt[9]  = '{1'b1, 0, 0,   24'h0,      16,   1'b1, 15, 15};
    vt[10] = '{1'b1, 1, int'(rf2), 24'h0, 16,  1'b1, 15, int'(rf2)};
    vt[11] = '{1'b1, 3, 0,   rk3,        112,  1'b0, 0, 0};

    reset_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    mode_s = 2'd0; fill_s = 8'h00; key_a = 24'h0; key_b = 8'h00;
    repeat (3) tick;
    chk("reset_addr_a", addr_a, 0);
    chk("reset_data_a", data_a, 0);
    chk("reset_we_a", we_a, 0);
    chk("reset_busy_a", busy_a, 0);
    chk("reset_finish_a", fin_a, 0);
    chk("reset_busy_b", busy_b, 0);
    reset_n = 1'b1;
    tick;

    for (int v = 0; v < 12; v++)
      run(vt[v].sel, vt[v].md, vt[v].fill, vt[v].key, vt[v].cyc, vt[v].chk_ad, vt[v].ad, vt[v].dat);

    // start while busy must be ignored: IDENTITY run with a FILL start pulse at cycle 100
    cur_sel = 1'b0; mode_s = 2'd0; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (99) tick;
    mode_s = 2'd1; fill_s = 8'h33; start_a = 1'b1;
    tick;
    start_a = 1'b0; mode_s = 2'd0;
    wait_done(100, cyc);
    chk("busy_start_ignored_cycles", cyc, 256);
    model_and_cmp(1'b0, 0, 0, 24'h0);

    // abort at cycle 400 of a KSA run
    mode_s = 2'd2; key_a = rk1; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (400) tick;
    abort_a = 1'b1;
    tick;
    abort_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_finish", fin_a, 0);
    chk("abort_we", we_a, 0);
    w0 = wr_a;
    repeat (20) tick;
    chk("abort_no_writes", wr_a, w0);
    chk("abort_stays_idle", busy_a, 0);
    run(1'b0, 3, 0, rk2, 1792, 1'b0, 0, 0);

    // abort and start together in DONE: start ignored
    mode_s = 2'd0; abort_a = 1'b1; start_a = 1'b1;
    tick;
    abort_a = 1'b0; start_a = 1'b0;
    chk("abort_start_done_finish", fin_a, 1);
    chk("abort_start_done_busy", busy_a, 0);
    tick;
    chk("abort_start_done_we", we_a, 0);

    // asynchronous reset in the middle of a KSA run
    mode_s = 2'd2; key_a = rk3; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (100) tick;
    reset_n = 1'b0;
    #1;
    chk("async_rst_addr", addr_a, 0);
    chk("async_rst_data", data_a, 0);
    chk("async_rst_we", we_a, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_finish", fin_a, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick;
    run(1'b0, 3, 0, 24'h000249, 1792, 1'b0, 0, 0);

    // randomized runs on both instances
    for (int r = 0; r < 8; r++) begin
      sel_r = int'($urandom_range(1, 0));
      md_r = int'($urandom_range(3, 0));
      fill_r = int'($urandom_range(255, 0));
      key_r = 24'($urandom);
      d_r = (sel_r != 0) ? 16 : 256;
      run(sel_r[0], md_r, fill_r, key_r, cycles_for(md_r, d_r), (md_r < 2),
          d_r - 1, (md_r == 1) ? fill_r : d_r - 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
